rect_render: RTL and testbench

RECT_RENDER -- requirements
Module: rect_render

---
 rtl/vga_pkg.sv | 37 +++
 rtl/signal_delay.sv | 28 ++
 rtl/rect_render.sv | 115 +++++++++++
 tb/tb_rect_render.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA constants, timing-bus struct and the rectangle span test.
package vga_pkg;

  localparam int H_VISIBLE = 800;
  localparam int H_TOTAL   = 1056;
  localparam int V_VISIBLE = 600;
  localparam int V_TOTAL   = 628;

  localparam int RGB_W = 12;
  localparam int CNT_W = 11;
  localparam int POS_W = 12;

  localparam int              RECT_WIDTH_DEF  = 48;
  localparam int              RECT_HEIGHT_DEF = 64;
  localparam logic [RGB_W-1:0] RECT_COLOR_DEF = 12'hF80;

  // Timing signals that travel together through the pipeline.
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic             hsync;
    logic             hblnk;
    logic [CNT_W-1:0] vcount;
    logic             vsync;
    logic             vblnk;
  } vga_tbus_t;

  localparam int TBUS_W = $bits(vga_tbus_t);

  // 13-bit span test: start+len never wraps, so a rectangle running past
  // 4095 is clipped rather than reappearing at the low edge.
  function automatic logic in_span(input logic [12:0] p,
                                   input logic [12:0] start,
                                   input logic [12:0] len);
    return (p >= start) && (p < start + len);
  endfunction

endpackage

// File: rtl/signal_delay.sv
// Fixed-latency shift register for an arbitrary-width bus.
module signal_delay #(
  parameter int WIDTH   = 8,
  parameter int CLK_DEL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [CLK_DEL-1:0][WIDTH-1:0] del_q, del_d;

  // Shift one stage per clock; stage 0 takes the input.
  always_comb begin
    del_d[0] = din;
    for (int i = 1; i < CLK_DEL; i++) del_d[i] = del_q[i-1];
  end

  // Pipeline storage, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) del_q <= '0;
    else     del_q <= del_d;
  end

  assign dout = del_q[CLK_DEL-1];

endmodule

// File: rtl/rect_render.sv
// Draws a solid rectangle over the incoming pixel stream. Position is
// latched once per frame on the vblnk rising edge; two-stage pipeline.
module rect_render
  import vga_pkg::*;
#(
  parameter int               RECT_WIDTH  = RECT_WIDTH_DEF,
  parameter int               RECT_HEIGHT = RECT_HEIGHT_DEF,
  parameter logic [11:0]      RECT_COLOR  = RECT_COLOR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic [10:0] hcount_in,
  input  logic        hsync_in,
  input  logic        hblnk_in,
  input  logic [10:0] vcount_in,
  input  logic        vsync_in,
  input  logic        vblnk_in,
  input  logic [11:0] rgb_in,
  output logic [10:0] hcount_out,
  output logic        hsync_out,
  output logic        hblnk_out,
  output logic [10:0] vcount_out,
  output logic        vsync_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out
);

  vga_tbus_t tbus_in, tbus_out;

  logic        vblnk_prev_q, vblnk_prev_d;
  logic [11:0] x_lat_q, x_lat_d;
  logic [11:0] y_lat_q, y_lat_d;
  logic        pos_valid_q, pos_valid_d;
  logic        vblnk_rise;
  logic        hit;
  logic        hit_q, hit_d;
  logic        blank_s1_q, blank_s1_d;
  logic [11:0] rgb_s1_q, rgb_s1_d;
  logic [11:0] rgb_out_q, rgb_out_d;

  // Timing bus rides a plain 2-cycle delay line to match the colour path.
  assign tbus_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                     vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

  signal_delay #(.WIDTH(TBUS_W), .CLK_DEL(2)) u_tbus_dly (
    .clk  (clk),
    .rst  (rst),
    .din  (tbus_in),
    .dout (tbus_out)
  );

  // Position shadow: capture only on vblnk rise so a frame never tears.
  always_comb begin
    vblnk_rise   = vblnk_in & ~vblnk_prev_q;
    vblnk_prev_d = vblnk_in;
    x_lat_d      = x_lat_q;
    y_lat_d      = y_lat_q;
    pos_valid_d  = pos_valid_q;
    if (vblnk_rise) begin
      x_lat_d     = xpos;
      y_lat_d     = ypos;
      pos_valid_d = 1'b1;
    end
  end

  // Stage 1: hit test against the latched position; gated by pos_valid.
  always_comb begin
    hit = in_span({2'b00, hcount_in}, {1'b0, x_lat_q}, 13'(RECT_WIDTH)) &
          in_span({2'b00, vcount_in}, {1'b0, y_lat_q}, 13'(RECT_HEIGHT));
    hit_d      = hit & pos_valid_q;
    blank_s1_d = hblnk_in | vblnk_in;
    rgb_s1_d   = rgb_in;
  end

  // Stage 2: blanking forces black, otherwise rectangle over background.
  always_comb begin
    if (blank_s1_q)  rgb_out_d = '0;
    else if (hit_q)  rgb_out_d = RECT_COLOR;
    else             rgb_out_d = rgb_s1_q;
  end

  // All state clears asynchronously, including the edge detector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_prev_q <= 1'b0;
      x_lat_q      <= '0;
      y_lat_q      <= '0;
      pos_valid_q  <= 1'b0;
      hit_q        <= 1'b0;
      blank_s1_q   <= 1'b0;
      rgb_s1_q     <= '0;
      rgb_out_q    <= '0;
    end else begin
      vblnk_prev_q <= vblnk_prev_d;
      x_lat_q      <= x_lat_d;
      y_lat_q      <= y_lat_d;
      pos_valid_q  <= pos_valid_d;
      hit_q        <= hit_d;
      blank_s1_q   <= blank_s1_d;
      rgb_s1_q     <= rgb_s1_d;
      rgb_out_q    <= rgb_out_d;
    end
  end

  assign hcount_out = tbus_out.hcount;
  assign hsync_out  = tbus_out.hsync;
  assign hblnk_out  = tbus_out.hblnk;
  assign vcount_out = tbus_out.vcount;
  assign vsync_out  = tbus_out.vsync;
  assign vblnk_out  = tbus_out.vblnk;
  assign rgb_out    = rgb_out_q;

endmodule

// File: tb/tb_rect_render.sv
// Random and directed pixel stimulus against a frame-level reference model.
module tb_rect_render;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, hblnk_in, vsync_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
  logic [11:0] rgb_out;

  rect_render dut (
    .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos),
    .hcount_in(hcount_in), .hsync_in(hsync_in), .hblnk_in(hblnk_in),
    .vcount_in(vcount_in), .vsync_in(vsync_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in),
    .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
    .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out)
  );

  always #5 clk = ~clk;

  localparam int          RW  = 48;
  localparam int          RH  = 64;
  localparam logic [11:0] COL = 12'hF80;

  int n_cmp = 0, n_bad = 0;

  // reference model state: position in force for the current frame
  int mx = 0, my = 0;
  bit mvalid = 0, mprev = 0;
  int cur_x = 0, cur_y = 0;
  logic rst_req;

  // expected outputs in flight (pipeline depth 2)
  logic [25:0] qb[$];
  logic [11:0] qr[$];

  wire [25:0] obus = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h want %h", tag, $time, got, exp);
    end
  endtask

  task automatic pop_check();
    if (qb.size() >= 2) begin
      chk("bus", 32'(obus), 32'(qb.pop_front()));
      chk("rgb", 32'(rgb_out), 32'(qr.pop_front()));
    end
  endtask

  // One pixel clock: check output due now, then apply new inputs.
  task automatic cyc(input int h, input int v, input bit hb, input bit vb);
    logic [11:0] r, er;
    logic hs, vs;
    @(negedge clk);
    pop_check();
    rst = rst_req;
    r  = 12'($urandom);
    hs = 1'($urandom);
    vs = 1'($urandom);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = hb; vblnk_in = vb; hsync_in = hs; vsync_in = vs;
    rgb_in = r; xpos = 12'(cur_x); ypos = 12'(cur_y);
    if (rst) begin
      qb.push_back('0); qr.push_back('0);
      mvalid = 0; mprev = 0;
    end else begin
      if (hb || vb) er = 12'h000;
      else if (mvalid && h >= mx && h < mx + RW && v >= my && v < my + RH) er = COL;
      else er = r;
      if (vb && !mprev) begin mx = cur_x; my = cur_y; mvalid = 1; end
      mprev = vb;
      qb.push_back({11'(h), hs, hb, 11'(v), vs, vb});
      qr.push_back(er);
    end
  endtask

  task automatic pix(input int h, input int v);
    cyc(h, v, h >= 800, v >= 600);
  endtask

  // Frame boundary; new position appears exactly on the rise cycle and is
  // scrambled right after so only the latched value may be used.
  task automatic new_frame(input int nx, input int ny);
    cyc(10, 599, 0, 0);
    cur_x = nx; cur_y = ny;
    cyc(0, 600, 0, 1);
    cur_x = int'($urandom_range(0, 4095));
    cur_y = int'($urandom_range(0, 4095));
    cyc(1, 601, 0, 1);
  endtask

  task automatic reset_mid(input int hold);
    @(posedge clk); #2;
    rst = 1'b1; rst_req = 1'b1;
    #1;
    chk("rst_rgb_now", 32'(rgb_out), 32'h0);
    chk("rst_bus_now", 32'(obus), 32'h0);
    qb.delete(); qr.delete();
    repeat (2) begin qb.push_back('0); qr.push_back('0); end
    mvalid = 0; mprev = 0;
    repeat (hold) pix(150, 301);
    rst_req = 1'b0;
  endtask

  initial begin
    int hs_[6];
    int vs_[4];
    rst = 1'b1; rst_req = 1'b1;
    xpos = '0; ypos = '0; hcount_in = '0; vcount_in = '0;
    hsync_in = 0; hblnk_in = 0; vsync_in = 0; vblnk_in = 0; rgb_in = '0;
    repeat (2) begin qb.push_back('0); qr.push_back('0); end
    repeat (4) pix(120, 220);          // reset state: all zero
    rst_req = 1'b0;

    // no latch yet: background passes through inside the would-be rectangle
    repeat (6) pix(5, 5);

    // scenario 1: boundary grid around (100,200)
    new_frame(100, 200);
    hs_ = '{99, 100, 101, 146, 147, 148};
    vs_ = '{199, 200, 263, 264};
    foreach (vs_[j]) foreach (hs_[i]) pix(hs_[i], vs_[j]);
    repeat (150) pix(int'($urandom_range(80, 170)), int'($urandom_range(180, 280)));

    // scenario 2: xpos moves mid-frame, takes effect next frame
    for (int v = 228; v < 233; v++) begin
      if (v == 230) cur_x = 300;
      pix(100, v); pix(147, v); pix(300, v); pix(347, v);
    end
    new_frame(300, 200);
    for (int v = 228; v < 233; v++) begin
      pix(100, v); pix(147, v); pix(299, v); pix(300, v); pix(347, v); pix(348, v);
    end

    // scenario 3: clipped at bottom-right, no wrap to top-left
    new_frame(780, 580);
    foreach (hs_[i]) hs_[i] = 0;
    for (int v = 578; v < 600; v += 3) begin
      pix(779, v); pix(780, v); pix(799, v); pix(800, v); pix(827, v);
      pix(0, v); pix(27, v);
    end
    for (int v = 0; v < 44; v += 7) begin pix(780, v); pix(799, v); end
    pix(790, 600); pix(790, 627);

    // scenario 4: reset mid-frame, nothing drawn until next vblnk rise
    new_frame(140, 280);
    for (int v = 296; v < 300; v++) begin pix(150, v); pix(139, v); end
    pix(150, 300);
    reset_mid(3);
    for (int v = 300; v < 320; v++) begin pix(150, v); pix(187, v); end
    new_frame(140, 280);
    for (int v = 300; v < 320; v += 4) begin pix(150, v); pix(188, v); end

    // scenario 6: rectangle overlapping blanking regions
    new_frame(770, 570);
    for (int k = 0; k < 40; k++) pix(int'($urandom_range(760, 900)), int'($urandom_range(560, 640)));
    cyc(790, 590, 1, 0); cyc(790, 590, 0, 1); cyc(790, 590, 1, 1);

    // off-screen and far-out-of-range positions plus random frames
    new_frame(900, 100);
    repeat (30) pix(int'($urandom_range(0, 1055)), int'($urandom_range(90, 170)));
    new_frame(2100, 4000);
    repeat (30) pix(int'($urandom_range(0, 1055)), int'($urandom_range(0, 627)));
    for (int f = 0; f < 25; f++) begin
      int nx, ny;
      nx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 850));
      ny = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4095)) : int'($urandom_range(0, 650));
      new_frame(nx, ny);
      repeat (200) begin
        int h, v;
        if ($urandom_range(0, 1) == 0) begin
          h = mx - 4 + int'($urandom_range(0, RW + 8));
          v = my - 4 + int'($urandom_range(0, RH + 8));
          if (h < 0) h = 0;
          if (h > 1055) h = 1055;
          if (v < 0) v = 0;
          if (v > 627) v = 627;
        end else begin
          h = int'($urandom_range(0, 1055));
          v = int'($urandom_range(0, 627));
        end
        pix(h, v);
      end
      if (f == 12) reset_mid(2);
    end

    repeat (2) pix(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
